temp_sample_controller: RTL

- Sequences periodic temperature acquisition for the Temperature_Monitor datapath.
- Requests a reading from the sensor interface using a req/valid handshake, then holds the reading on the monitor's temperature input.
- Evaluates the monitor's high/low flags one cycle later.
- Turns persistent out-of-range readings into latched caregiver alarms, and raises a fault if the sensor does not respond.

---
 rtl/temp_sample_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/temp_sample_controller.sv
// Sample sequencer for the temperature monitor datapath.
// Requests readings, evaluates monitor flags, latches alarms and faults.
module temp_sample_controller #(
    parameter int          SAMPLE_PERIOD = 1000,
    parameter int          TIMEOUT       = 16,
    parameter int          PERSIST       = 3,
    parameter logic [7:0]  INIT_TEMP     = 8'd98
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       sample_req,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    output logic [7:0] temp_to_mon,
    input  logic       mon_high,
    input  logic       mon_low,
    input  logic       alarm_ack,
    output logic       alarm_high,
    output logic       alarm_low,
    output logic       sensor_fault,
    output logic       busy
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(PERSIST + 1);

    localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(PERSIST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EVAL = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] period_cnt, period_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [CW-1:0] high_cnt, high_n;
    logic [CW-1:0] low_cnt, low_n;
    logic [7:0]    temp_n;
    logic          alarm_high_n;
    logic          alarm_low_n;
    logic          sensor_fault_n;

    logic [CW-1:0] high_sat;
    logic [CW-1:0] low_sat;

    // Saturating increments keep the persistence counters from wrapping.
    assign high_sat = (high_cnt == C_MAX) ? C_MAX : high_cnt + 1'b1;
    assign low_sat  = (low_cnt == C_MAX) ? C_MAX : low_cnt + 1'b1;

    assign sample_req = (state == REQ);
    assign busy       = (state != IDLE);

    // State and datapath registers; reset takes effect without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            period_cnt   <= '0;
            wait_cnt     <= '0;
            high_cnt     <= '0;
            low_cnt      <= '0;
            temp_to_mon  <= INIT_TEMP;
            alarm_high   <= 1'b0;
            alarm_low    <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            state        <= state_n;
            period_cnt   <= period_n;
            wait_cnt     <= wait_n;
            high_cnt     <= high_n;
            low_cnt      <= low_n;
            temp_to_mon  <= temp_n;
            alarm_high   <= alarm_high_n;
            alarm_low    <= alarm_low_n;
            sensor_fault <= sensor_fault_n;
        end
    end

    // Next-state logic; ack clears first so a same-cycle set overrides it.
    always_comb begin
        state_n        = state;
        period_n       = period_cnt;
        wait_n         = wait_cnt;
        high_n         = high_cnt;
        low_n          = low_cnt;
        temp_n         = temp_to_mon;
        alarm_high_n   = alarm_high;
        alarm_low_n    = alarm_low;
        sensor_fault_n = sensor_fault;

        if (alarm_ack) begin
            alarm_high_n   = 1'b0;
            alarm_low_n    = 1'b0;
            sensor_fault_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (!enable) begin
                    period_n = '0;
                end else if (period_cnt == P_LAST) begin
                    period_n = '0;
                    state_n  = REQ;
                end else begin
                    period_n = period_cnt + 1'b1;
                end
            end
            REQ: begin
                if (sample_valid) begin
                    temp_n         = sample_data;
                    wait_n         = '0;
                    sensor_fault_n = 1'b0;
                    state_n        = EVAL;
                end else if (wait_cnt == W_LAST) begin
                    sensor_fault_n = 1'b1;
                    wait_n         = '0;
                    state_n        = IDLE;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            EVAL: begin
                state_n = IDLE;
                unique case ({mon_high, mon_low})
                    2'b10: begin
                        high_n = high_sat;
                        low_n  = '0;
                        if (high_sat == C_MAX) alarm_high_n = 1'b1;
                    end
                    2'b01: begin
                        low_n  = low_sat;
                        high_n = '0;
                        if (low_sat == C_MAX) alarm_low_n = 1'b1;
                    end
                    2'b00: begin
                        high_n = '0;
                        low_n  = '0;
                    end
                    default: begin
                        high_n = high_cnt;
                        low_n  = low_cnt;
                    end
                endcase
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
